// File: rtl/uart_prog_pkg.sv
// Shared definitions for the uart_prog page buffer: page geometry,
// programmer MODE encodings, FSM state codes and the debug view struct.
package uart_prog_pkg;

    // Page geometry; DEPTH must match the programmer's bytes per program op.
    localparam int DEPTH  = 256;
    localparam int ADDR_W = 8;

    // Programmer command encodings.
    localparam logic [2:0] MODE_IDLE       = 3'b000;
    localparam logic [2:0] MODE_READ       = 3'b010;
    localparam logic [2:0] MODE_ERASE_PROG = 3'b110;

    // Page buffer FSM states.
    localparam logic [1:0] ST_FILL    = 2'd0;
    localparam logic [1:0] ST_PAD     = 2'd1;
    localparam logic [1:0] ST_PROGRAM = 2'd2;
    localparam logic [1:0] ST_DONE    = 2'd3;

    // Observable internal state of the page buffer.
    typedef struct packed {
        logic [1:0]        state;
        logic [ADDR_W-1:0] wr_ptr;
        logic [ADDR_W-1:0] rd_ptr;
        logic [ADDR_W:0]   consumed;
    } dbg_t;

endpackage

// File: rtl/uart_prog_page_buf_if.sv
// Bus bundle between the UART side / programmer side and the page buffer.
//
// Handshake semantics:
//   RX_VALID is a one-cycle strobe; RX_DATA is valid in that same cycle and
//   there is no back-pressure (a byte arriving outside FILL is dropped and
//   flagged on OVERFLOW).
//   DATA2 always shows the byte at the read pointer. The programmer consumes
//   that byte by raising NEW_DATA2; only the rising edge (as seen at posedge
//   CLK) counts, so a request held high for several cycles advances once.
//   The following byte appears on DATA2 one cycle after the advance.
interface uart_prog_page_buf_if;
    import uart_prog_pkg::*;

    logic [7:0] RX_DATA;
    logic       RX_VALID;
    logic [7:0] DATA2;
    logic       NEW_DATA2;
    logic [2:0] MODE;
    logic       BUSY;
    logic       DONE;
    logic       OVERFLOW;
    dbg_t       DBG;

    // Driver side: UART receiver plus programmer.
    modport master (
        output RX_DATA, RX_VALID, NEW_DATA2,
        input  DATA2, MODE, BUSY, DONE, OVERFLOW, DBG
    );

    // Page buffer side.
    modport slave (
        input  RX_DATA, RX_VALID, NEW_DATA2,
        output DATA2, MODE, BUSY, DONE, OVERFLOW, DBG
    );

endinterface

// File: rtl/prog_req_edge.sv
// Request edge detector for the programmer's NEW_DATA2 line. The programmer
// runs on the same clock, so no extra synchroniser stage is inserted; the
// advance pulse is the raw request AND NOT its registered copy, which gives
// exactly one pulse per request regardless of how long it is held.
module prog_req_edge (
    input  logic clk_i,
    input  logic rst_n_i,
    input  logic req_i,
    output logic advance_o
);

    logic req_q;
    logic req_d;

    // Next value of the request history is simply the current request.
    always_comb begin
        req_d = req_i;
    end

    // Register the previous request level.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            req_q <= 1'b0;
        end else begin
            req_q <= req_d;
        end
    end

    assign advance_o = req_i & ~req_q;

endmodule

// File: rtl/uart_prog_page_buf.sv
// Page buffer between the UART receiver and the flash SPI programmer.
// Collects a page of bytes, pads it with PAD after an idle timeout, then
// commands Erase & Program and serves the bytes one per programmer request.
// A reset while programming returns to FILL; the programmer itself is not
// reset, so recovering from that case needs a reconfiguration.
module uart_prog_page_buf
    import uart_prog_pkg::*;
#(
    parameter int         TIMEOUT = 4_800_000,
    parameter logic [7:0] PAD     = 8'hFF
) (
    input logic                  CLK,
    input logic                  RST_N,
    uart_prog_page_buf_if.slave  bus
);

    localparam int IDLE_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    logic [1:0]        state_q,    state_d;
    logic [ADDR_W-1:0] wr_ptr_q,   wr_ptr_d;
    logic [ADDR_W-1:0] rd_ptr_q,   rd_ptr_d;
    logic [ADDR_W:0]   consumed_q, consumed_d;
    logic [IDLE_W-1:0] idle_q,     idle_d;
    logic [2:0]        mode_q,     mode_d;
    logic              busy_q,     busy_d;
    logic              done_q,     done_d;
    logic              ovf_q,      ovf_d;

    // Page storage: one write port, asynchronous read. Never reset.
    logic [7:0]        mem_q [DEPTH];
    logic              wr_en;
    logic [7:0]        wr_data;
    logic              advance;

    prog_req_edge u_req_edge (
        .clk_i     (CLK),
        .rst_n_i   (RST_N),
        .req_i     (bus.NEW_DATA2),
        .advance_o (advance)
    );

    // FSM next state, pointer updates, write enable and sticky flags.
    always_comb begin
        state_d    = state_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        consumed_d = consumed_q;
        idle_d     = idle_q;
        ovf_d      = ovf_q;
        wr_en      = 1'b0;
        wr_data    = bus.RX_DATA;

        case (state_q)
            ST_FILL: begin
                if (bus.RX_VALID) begin
                    wr_en    = 1'b1;
                    wr_ptr_d = wr_ptr_q + 1'b1;
                    idle_d   = '0;
                    if (wr_ptr_q == ADDR_W'(DEPTH - 1)) begin
                        state_d = ST_PROGRAM;
                    end
                end else if (wr_ptr_q != '0) begin
                    // An empty page never times out, so it never programs.
                    if (idle_q == IDLE_W'(TIMEOUT - 1)) begin
                        state_d = ST_PAD;
                        idle_d  = '0;
                    end else begin
                        idle_d = idle_q + 1'b1;
                    end
                end
            end
            ST_PAD: begin
                wr_en    = 1'b1;
                wr_data  = PAD;
                wr_ptr_d = wr_ptr_q + 1'b1;
                if (wr_ptr_q == ADDR_W'(DEPTH - 1)) begin
                    state_d = ST_PROGRAM;
                end
            end
            ST_PROGRAM: begin
                if (advance) begin
                    rd_ptr_d   = rd_ptr_q + 1'b1;
                    consumed_d = consumed_q + 1'b1;
                    if (consumed_q == (ADDR_W + 1)'(DEPTH - 1)) begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_DONE;
            end
            default: begin
                state_d = ST_FILL;
            end
        endcase

        // Bytes can only be accepted while filling; anything else is lost.
        if (bus.RX_VALID && (state_q != ST_FILL)) begin
            ovf_d = 1'b1;
        end
    end

    // Registered programmer-facing outputs follow the next state.
    always_comb begin
        mode_d = (state_d == ST_PROGRAM) ? MODE_ERASE_PROG : MODE_IDLE;
        busy_d = (state_d == ST_PROGRAM);
        done_d = done_q | (state_d == ST_DONE);
    end

    // State and control registers with synchronous active-low reset.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state_q    <= ST_FILL;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            consumed_q <= '0;
            idle_q     <= '0;
            mode_q     <= MODE_IDLE;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            ovf_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            consumed_q <= consumed_d;
            idle_q     <= idle_d;
            mode_q     <= mode_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            ovf_q      <= ovf_d;
        end
    end

    // Page memory write port; contents survive reset.
    always_ff @(posedge CLK) begin
        if (wr_en) begin
            mem_q[wr_ptr_q] <= wr_data;
        end
    end

    assign bus.DATA2    = mem_q[rd_ptr_q];
    assign bus.MODE     = mode_q;
    assign bus.BUSY     = busy_q;
    assign bus.DONE     = done_q;
    assign bus.OVERFLOW = ovf_q;
    assign bus.DBG      = {state_q, wr_ptr_q, rd_ptr_q, consumed_q};

endmodule

// File: tb/tb_uart_prog_page_buf.sv
// Bench for uart_prog_page_buf: a table of page scenarios (fill length,
// data base, request width, overflow injection) each run through a full
// fill / program / done cycle, plus hand sequences for reset state, the
// empty-page case, timeout/pad timing and reset in the middle of PROGRAM.
module tb_uart_prog_page_buf;
    import uart_prog_pkg::*;

    localparam int TIMEOUT = 16;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    uart_prog_page_buf_if bus();

    uart_prog_page_buf #(
        .TIMEOUT (TIMEOUT),
        .PAD     (8'hFF)
    ) dut (
        .CLK   (clk),
        .RST_N (rst_n),
        .bus   (bus)
    );

    typedef struct {
        int         n_bytes;
        logic [7:0] base;
        int         req_hi;
        bit         inject;
        logic       exp_ovf;
    } vec_t;

    vec_t       vecs [5];
    logic [7:0] exp_q [$];
    int         n_checks = 0;
    int         n_errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        rst_n         = 1'b0;
        bus.RX_VALID  = 1'b0;
        bus.RX_DATA   = 8'h00;
        bus.NEW_DATA2 = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic send_bytes(input int n, input logic [7:0] base);
        for (int i = 0; i < n; i++) begin
            bus.RX_VALID = 1'b1;
            bus.RX_DATA  = base + 8'(i);
            @(negedge clk);
        end
        bus.RX_VALID = 1'b0;
    endtask

    task automatic send_stray(input logic [7:0] b);
        bus.RX_VALID = 1'b1;
        bus.RX_DATA  = b;
        @(negedge clk);
        bus.RX_VALID = 1'b0;
    endtask

    // One programmer request: high for hi cycles, 8-cycle period overall.
    task automatic do_req(input int hi);
        bus.NEW_DATA2 = 1'b1;
        repeat (hi) @(negedge clk);
        bus.NEW_DATA2 = 1'b0;
        repeat (8 - hi) @(negedge clk);
    endtask

    task automatic wait_state(input logic [1:0] st, input int budget, input string name);
        int c;
        c = 0;
        while (bus.DBG.state !== st && c < budget) begin
            @(negedge clk);
            c++;
        end
        chk(name, 32'(bus.DBG.state), 32'(st));
    endtask

    task automatic check_reset_state(input string tag);
        chk({tag, "_state"},  32'(bus.DBG.state),  32'(ST_FILL));
        chk({tag, "_wrptr"},  32'(bus.DBG.wr_ptr), 32'd0);
        chk({tag, "_rdptr"},  32'(bus.DBG.rd_ptr), 32'd0);
        chk({tag, "_mode"},   32'(bus.MODE),       32'(3'b000));
        chk({tag, "_busy"},   32'(bus.BUSY),       32'd0);
        chk({tag, "_done"},   32'(bus.DONE),       32'd0);
        chk({tag, "_ovf"},    32'(bus.OVERFLOW),   32'd0);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int         c;
        logic [7:0] e;

        vecs[0] = '{n_bytes: 256, base: 8'h00, req_hi: 1, inject: 1'b0, exp_ovf: 1'b0};
        vecs[1] = '{n_bytes: 10,  base: 8'hA0, req_hi: 1, inject: 1'b0, exp_ovf: 1'b0};
        vecs[2] = '{n_bytes: 256, base: 8'h30, req_hi: 3, inject: 1'b0, exp_ovf: 1'b0};
        vecs[3] = '{n_bytes: 256, base: 8'h00, req_hi: 1, inject: 1'b1, exp_ovf: 1'b1};
        vecs[4] = '{n_bytes: 1,   base: 8'h5A, req_hi: 3, inject: 1'b1, exp_ovf: 1'b1};

        do_reset();
        check_reset_state("reset");

        // Empty page: the idle timeout must never run.
        repeat (3 * TIMEOUT + 5) @(negedge clk);
        chk("empty_state", 32'(bus.DBG.state), 32'(ST_FILL));
        chk("empty_mode",  32'(bus.MODE),      32'(3'b000));

        // Table of full page scenarios.
        for (int v = 0; v < 5; v++) begin
            do_reset();
            exp_q.delete();
            for (int i = 0; i < DEPTH; i++) begin
                exp_q.push_back((i < vecs[v].n_bytes) ? vecs[v].base + 8'(i) : 8'hFF);
            end
            send_bytes(vecs[v].n_bytes, vecs[v].base);
            if (vecs[v].n_bytes == DEPTH) begin
                chk("full_enter_program", 32'(bus.DBG.state), 32'(ST_PROGRAM));
            end else begin
                wait_state(ST_PROGRAM, TIMEOUT + DEPTH + 20, "pad_enter_program");
            end
            chk("prog_mode", 32'(bus.MODE), 32'(3'b110));
            chk("prog_busy", 32'(bus.BUSY), 32'd1);
            for (int r = 0; r < DEPTH; r++) begin
                if (vecs[v].inject && r == 50) begin
                    send_stray(8'h55);
                    chk("ovf_set", 32'(bus.OVERFLOW), 32'd1);
                end
                e = exp_q.pop_front();
                chk($sformatf("data2_v%0d_r%0d", v, r), 32'(bus.DATA2), 32'(e));
                do_req(vecs[v].req_hi);
            end
            chk("done_state",    32'(bus.DBG.state),    32'(ST_DONE));
            chk("done_flag",     32'(bus.DONE),         32'd1);
            chk("done_mode",     32'(bus.MODE),         32'(3'b000));
            chk("done_busy",     32'(bus.BUSY),         32'd0);
            chk("done_consumed", 32'(bus.DBG.consumed), 32'd256);
            chk("done_ovf",      32'(bus.OVERFLOW),     32'(vecs[v].exp_ovf));
            // More requests after DONE must not change anything.
            do_req(1);
            chk("done_hold", 32'(bus.DONE), 32'd1);
        end

        // Timeout and pad timing: 16 idle cycles, then 246 pad cycles.
        do_reset();
        send_bytes(10, 8'hA0);
        c = 0;
        while (bus.DBG.state !== ST_PAD && c < 100) begin
            @(negedge clk);
            c++;
        end
        chk("timeout_cycles", 32'(c), 32'(TIMEOUT));
        c = 0;
        while (bus.DBG.state === ST_PAD && c < 300) begin
            @(negedge clk);
            c++;
        end
        chk("pad_cycles",  32'(c),              32'd246);
        chk("pad_to_prog", 32'(bus.DBG.state),  32'(ST_PROGRAM));

        // Reset in the middle of PROGRAM after 100 requests.
        do_reset();
        send_bytes(DEPTH, 8'h80);
        chk("mid_program", 32'(bus.DBG.state), 32'(ST_PROGRAM));
        for (int r = 0; r < 100; r++) begin
            do_req(1);
        end
        chk("mid_data2", 32'(bus.DATA2), 32'(8'hE4));
        send_stray(8'h55);
        chk("mid_ovf", 32'(bus.OVERFLOW), 32'd1);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check_reset_state("midrst");
        chk("midrst_mem_kept", 32'(bus.DATA2), 32'(8'h80));
        repeat (3 * TIMEOUT) @(negedge clk);
        chk("midrst_idle_state", 32'(bus.DBG.state), 32'(ST_FILL));
        chk("midrst_idle_mode",  32'(bus.MODE),      32'(3'b000));

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
